// File: rtl/orient_kp_collector.sv
// orient_kp_collector
//   Sequences keypoint orientation capture around the 7x7 moment unit.
//   Tracks raster position and a 7-column validity history over the incoming
//   column stream, delays each FAST keypoint flag by four clocks to line it up
//   with the moment unit's output, and queues complete (x, y, mx, my) records
//   in a small show-ahead FIFO drained over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_sof, i_sol            frame start (implies row start), row start
//   i_col_valid, i_kp       column present this cycle, centre pixel is a keypoint
//   i_mx, i_my              signed moment-unit outputs (aligned to the 4-deep delay)
//   o_kp_valid, i_kp_ready  FIFO head handshake
//   o_kp_x/y/mx/my          FIFO head record
//   o_overflow              sticky drop flag, cleared on i_sof
//   o_drop_cnt              saturating drop counter (only with ORIENT_DROP_CNT_EN)
//
// Configuration
//   ORIENT_DROP_CNT_EN  adds the 16-bit o_drop_cnt output and its counter.
//
// WIDTH and HEIGHT must fit the 10-bit coordinate fields (<= 1023).

module orient_kp_collector #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sof,
    input  logic               i_sol,
    input  logic               i_col_valid,
    input  logic               i_kp,
    input  logic signed [15:0] i_mx,
    input  logic signed [15:0] i_my,
    output logic               o_kp_valid,
    input  logic               i_kp_ready,
    output logic [9:0]         o_kp_x,
    output logic [9:0]         o_kp_y,
    output logic signed [15:0] o_kp_mx,
    output logic signed [15:0] o_kp_my,
    output logic               o_overflow
`ifdef ORIENT_DROP_CNT_EN
    ,
    output logic [15:0]        o_drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] W_SAT = 10'(WIDTH);
    localparam logic [9:0] H_SAT = 10'(HEIGHT);

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] mx;
        logic [15:0] my;
    } rec_t;

    typedef struct packed {
        logic       kp;
        logic [9:0] x;
        logic [9:0] y;
    } kp_t;

    logic [9:0]  x_next;   // index the next non-row-start valid column will take
    logic [9:0]  y_reg;    // current row index
    logic [9:0]  x_cur;
    logic [9:0]  y_cur;
    logic [6:0]  hist;
    kp_t         kp_pipe [4];
    rec_t        mem [FIFO_DEPTH];
    rec_t        wr_rec;
    rec_t        head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        commit;

    // Position of the column presented this cycle; row/frame starts take
    // effect in the same cycle so the first column of a row is x=0.
    always_comb begin
        x_cur = i_sol ? 10'd0 : x_next;
        y_cur = y_reg;
        if (i_sof)
            y_cur = 10'd0;
        else if (i_sol)
            y_cur = (y_reg < H_SAT) ? y_reg + 10'd1 : H_SAT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_next <= '0;
            y_reg  <= '0;
        end else begin
            if (i_col_valid)
                x_next <= (x_cur < W_SAT) ? x_cur + 10'd1 : W_SAT;
            y_reg <= y_cur;
        end
    end

    // hist[0] is the newest column. A row start discards older columns, so a
    // window touching a previous row, a stall or the image edge is never full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            hist <= '0;
        else if (i_sol)
            hist <= {6'b0, i_col_valid};
        else
            hist <= {hist[5:0], i_col_valid};
    end

    // Four stages: a keypoint captured at cycle t sits in stage 3 during t+4,
    // when hist spans columns t-3..t+3 and the moment unit reports column t.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++)
                kp_pipe[i] <= '0;
        end else begin
            kp_pipe[0].kp <= i_col_valid & i_kp & (x_cur < W_SAT) & (y_cur >= 10'd6);
            kp_pipe[0].x  <= x_cur;
            kp_pipe[0].y  <= y_cur - 10'd3;
            for (int i = 1; i < 4; i++)
                kp_pipe[i] <= kp_pipe[i-1];
        end
    end

    assign commit = kp_pipe[3].kp & (hist == 7'h7F);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & i_kp_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = commit & (~full | pop);
    assign drop  = commit & full & ~pop;

    always_comb begin
        wr_rec    = '0;
        wr_rec.x  = kp_pipe[3].x;
        wr_rec.y  = kp_pipe[3].y;
        wr_rec.mx = i_mx;
        wr_rec.my = i_my;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_rec;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A drop coinciding with a frame start must stay visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_overflow <= 1'b0;
        else if (drop)
            o_overflow <= 1'b1;
        else if (i_sof)
            o_overflow <= 1'b0;
    end

`ifdef ORIENT_DROP_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_drop_cnt <= '0;
        else if (i_sof)
            o_drop_cnt <= {15'd0, drop};
        else if (drop && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`endif

    assign head       = mem[rd_ptr[AW-1:0]];
    assign o_kp_valid = ~empty;
    assign o_kp_x     = head.x;
    assign o_kp_y     = head.y;
    assign o_kp_mx    = head.mx;
    assign o_kp_my    = head.my;

endmodule
